// File: rtl/ticket_dispense_arbiter.sv
// Round-robin arbiter that shares one ticket printer and one coin hopper among
// several sale front-ends, sequencing print/coin strobes for the granted transaction.
module ticket_dispense_arbiter #(
    parameter int N_REQ        = 4,
    parameter int PRINT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [3*N_REQ-1:0]   req_tickets,
    input  logic [7*N_REQ-1:0]   req_change,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic                 print_pulse,
    output logic                 coin5_pulse,
    output logic                 coin1_pulse,
    output logic                 busy
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int SLOT_W = (PRINT_CYCLES > 1) ? $clog2(PRINT_CYCLES) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PRINT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRINT, CHANGE, DONE} state_t;

    state_t              state, state_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [IDX_W-1:0]    last_grant, last_grant_n;
    logic [2:0]          tickets_left, tickets_left_n;
    logic [SLOT_W-1:0]   slot, slot_n;
    logic [6:0]          change_left, change_left_n;

    logic [N_REQ-1:0]    grant_n, done_n;
    logic                print_n, coin5_n, coin1_n;

    logic                found;
    logic [IDX_W:0]      cand;
    logic [IDX_W-1:0]    pick;
    logic [2:0]          pick_tickets;
    logic [6:0]          pick_change;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            last_grant   <= IDX_W'(N_REQ - 1);
            tickets_left <= '0;
            slot         <= '0;
            change_left  <= '0;
            grant        <= '0;
            done         <= '0;
            print_pulse  <= 1'b0;
            coin5_pulse  <= 1'b0;
            coin1_pulse  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            last_grant   <= last_grant_n;
            tickets_left <= tickets_left_n;
            slot         <= slot_n;
            change_left  <= change_left_n;
            grant        <= grant_n;
            done         <= done_n;
            print_pulse  <= print_n;
            coin5_pulse  <= coin5_n;
            coin1_pulse  <= coin1_n;
            busy         <= (state_n != IDLE);
        end
    end

    always_comb begin
        found          = 1'b0;
        cand           = '0;
        pick           = '0;
        state_n        = state;
        idx_n          = idx;
        last_grant_n   = last_grant;
        tickets_left_n = tickets_left;
        slot_n         = slot;
        change_left_n  = change_left;
        grant_n        = '0;
        done_n         = '0;
        print_n        = 1'b0;
        coin5_n        = 1'b0;
        coin1_n        = 1'b0;

        // Search upward from the requester after the last one served, wrapping.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_grant} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ))
                cand = cand - (IDX_W+1)'(N_REQ);
            if (!found && req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end

        pick_tickets = req_tickets[3*pick +: 3];
        if (pick_tickets > 3'd5)
            pick_tickets = 3'd5;
        pick_change = req_change[7*pick +: 7];

        case (state)
            IDLE: begin
                if (found) begin
                    idx_n          = pick;
                    tickets_left_n = pick_tickets;
                    change_left_n  = pick_change;
                    slot_n         = '0;
                    if (pick_tickets != 3'd0)
                        state_n = PRINT;
                    else if (pick_change != 7'd0)
                        state_n = CHANGE;
                    else
                        state_n = DONE;
                end
            end
            PRINT: begin
                if (slot == SLOT_LAST) begin
                    slot_n = '0;
                    if (tickets_left == 3'd1) begin
                        tickets_left_n = 3'd0;
                        state_n = (change_left != 7'd0) ? CHANGE : DONE;
                    end else begin
                        tickets_left_n = tickets_left - 3'd1;
                    end
                end else begin
                    slot_n = slot + SLOT_W'(1);
                end
            end
            CHANGE: begin
                change_left_n = (change_left >= 7'd5) ? change_left - 7'd5
                                                      : change_left - 7'd1;
                if (change_left_n == 7'd0)
                    state_n = DONE;
            end
            DONE: begin
                last_grant_n = idx;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered, so decode them from the upcoming state.
        if (state_n != IDLE)
            grant_n[idx_n] = 1'b1;
        if (state_n == DONE)
            done_n[idx_n] = 1'b1;
        print_n = (state_n == PRINT) && (slot_n == '0);
        coin5_n = (state_n == CHANGE) && (change_left_n >= 7'd5);
        coin1_n = (state_n == CHANGE) && (change_left_n <  7'd5);
    end

endmodule

// File: doc/ticket_dispense_arbiter.md
# ticket_dispense_arbiter

Shares one ticket printer and one coin-change hopper among several ticket-sale front-ends. Each front-end raises a request with its finished transaction (ticket count, change owed). The block grants one requester at a time in round-robin order and sequences the printer and hopper pulses for that transaction. It then returns a completion pulse to that requester.

## Interface

- N_REQ, 4, number of front-end requesters (2..8)
- PRINT_CYCLES, 4, cycles per ticket slot (print pulse plus gap), minimum 1
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester service request, level
- req_tickets  in  3*N_REQ  ticket count per requester, slice i = [3i+2:3i]
- req_change  in  7*N_REQ  change owed per requester in unit coins, slice i = [7i+6:7i]
- grant  out  N_REQ  one-hot, high for the whole service of the granted requester
- done  out  N_REQ  one-cycle completion pulse to the granted requester
- print_pulse  out  1  one-cycle strobe, one per ticket printed
- coin5_pulse  out  1  one-cycle strobe, dispense one 5-unit coin
- coin1_pulse  out  1  one-cycle strobe, dispense one 1-unit coin
- busy  out  1  high whenever state is not IDLE

## Operation

- States: IDLE, PRINT, CHANGE, DONE. All outputs are registered.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise choose the first set req bit, searching upward from (last_grant+1) mod N_REQ with wrap.
  - At that clock edge, latch the index, that requester's tickets and that requester's change.
  - Set grant.
  - Go to PRINT if tickets>0. Else go to CHANGE if change>0. Else go to DONE.
- Ticket clamp: latched tickets of 6 or 7 are clamped to 5.
- PRINT:
  - A slot counter runs 0..PRINT_CYCLES-1 and a ticket counter counts down.
  - print_pulse is high when the slot counter is 0.
  - At the end of the last slot of the last ticket, go to CHANGE if change>0, else go to DONE.
- CHANGE: one coin per cycle.
  - If remaining change is 5 or more, assert coin5_pulse and subtract 5.
  - Otherwise assert coin1_pulse and subtract 1.
  - After the cycle that brings the remainder to 0, go to DONE.
- DONE:
  - done[idx] is high for one cycle and grant is still high.
  - At the next edge: grant clears, last_grant<=idx, go to IDLE.
- Latched values are used for the whole service. Changes to req, req_tickets or req_change during service are ignored.
- Dropping req mid-service does not abort the service.
- A req still high in IDLE after its done pulse counts as a new request. Round-robin order gives every other pending requester service first.
- At most one of print_pulse, coin5_pulse, coin1_pulse is high in any cycle.

## Timing

- Reset:
  - All outputs are 0 and state is IDLE.
  - Counters and latched values are cleared.
  - last_grant is N_REQ-1, so requester 0 has top priority first.
- Reset during service: the transaction is discarded with no done pulse. Outputs are 0 the cycle after reset is sampled.
- Request latency: req sampled high in cycle t → grant high from cycle t+1.
- First print_pulse is in cycle t+1 when tickets>0.
- Grant duration is tickets*PRINT_CYCLES + coins + 1 cycles.
  - coins = floor(change/5) + change mod 5.
  - The final +1 is the DONE cycle.
- Back-to-back service: the earliest next grant rises 2 cycles after done, because one IDLE cycle is always spent.
- Zero transaction (tickets=0, change=0): grant lasts 1 cycle (DONE only). done pulses in cycle t+1.

## Test plan

- Reset, then req=0001, tickets=2, change=12, PRINT_CYCLES=4:
  - grant=0001 for 13 cycles.
  - print_pulse in cycles t+1 and t+5.
  - coin5 in cycles t+9 and t+10; coin1 in cycles t+11 and t+12.
  - done[0] in cycle t+13.
- req=1111 held, every requester with tickets=1 and change=0:
  - Grants go 0,1,2,3,0 in that order.
  - Each grant lasts 5 cycles, with one idle cycle between grants.
- tickets=7, change=0 → exactly 5 print_pulses, then done.
- tickets=0, change=0 on requester 2 → grant=0100 for 1 cycle, done[2] in the same cycle, no strobes.
- Assert reset at the 3rd coin of a change=20 service:
  - All outputs are 0 the next cycle and no done pulse occurs.
  - After reset, with req=1000 and req=0001 pending, requester 0 is granted first.
- Drop req and change req_change mid-PRINT → the service completes with the latched values and done still pulses.
